// File: rtl/spi_mem_ctrl_if.sv
// spi_mem_ctrl_if: request/response bundle between a memory requester and the SPI controller.
interface spi_mem_ctrl_if #(
    parameter int ADDR_BITS = 24,
    parameter int CS_BITS   = 1,
    parameter int MAX_BYTES = 4
) ();
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [3:0]                    req_num_bytes;
    logic [CS_BITS+ADDR_BITS-1:0]  req_addr;
    logic [8*MAX_BYTES-1:0]        req_wdata;
    logic                          rsp_valid;
    logic [8*MAX_BYTES-1:0]        rsp_rdata;
    modport master (
        output req_valid, req_write, req_num_bytes, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_write, req_num_bytes, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: mode-0 SPI master for serial flash/RAM with chip-select decode and registered SCLK.
module spi_mem_ctrl #(
    parameter int ADDR_BITS = 24,
    parameter int CS_BITS   = 1,
    parameter int MAX_BYTES = 4,
    parameter int CLK_DIV   = 1,
    parameter int CS_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_mem_ctrl_if.slave         bus,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [2**CS_BITS-1:0] cs_n
);
    localparam int NCS  = 2**CS_BITS;
    localparam int HDR  = 8 + ADDR_BITS;
    localparam int W    = HDR + 8*MAX_BYTES;
    localparam int CW   = $clog2(W + 1);
    localparam int RW   = $clog2(8*MAX_BYTES);
    localparam int DW   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int GW   = CS_GAP > 1 ? $clog2(CS_GAP) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

    state_e                 state_q;
    logic [W-1:0]           sr_q, sr_d;
    logic [CW-1:0]          n_q, n_d, fall_q;
    logic [DW-1:0]          div_q;
    logic [GW-1:0]          gap_q;
    logic [3:0]             nb_d;
    logic [RW-1:0]          rx_idx;
    logic                   write_q, sclk_q, mosi_q, rsp_valid_q;
    logic [NCS-1:0]         cs_n_q;
    logic [8*MAX_BYTES-1:0] rdata_q;

    assign bus.req_ready = (state_q == IDLE) & ~rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign sclk          = sclk_q;
    assign mosi          = mosi_q;
    assign cs_n          = cs_n_q;

    assign nb_d   = (bus.req_num_bytes == 4'd0 || bus.req_num_bytes > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : bus.req_num_bytes;
    assign n_d    = CW'(HDR) + CW'({nb_d, 3'b000});
    // Data bit j lands in byte j/8 at position 7-j%8, which is simply j^7.
    assign rx_idx = RW'(fall_q - CW'(HDR)) ^ RW'(7);

    // Frame: opcode, address, then data bytes byte0 first; reads clock out zeros.
    always_comb begin
        sr_d = '0;
        sr_d[W-1 -: 8] = bus.req_write ? 8'h02 : 8'h03;
        sr_d[W-9 -: ADDR_BITS] = bus.req_addr[ADDR_BITS-1:0];
        for (int k = 0; k < MAX_BYTES; k++)
            sr_d[W-HDR-1-8*k -: 8] = bus.req_write ? bus.req_wdata[8*k +: 8] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            n_q         <= '0;
            fall_q      <= '0;
            div_q       <= '0;
            gap_q       <= '0;
            write_q     <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= '1;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    state_q <= SHIFT;
                    sr_q    <= sr_d;
                    mosi_q  <= sr_d[W-1];
                    n_q     <= n_d;
                    write_q <= bus.req_write;
                    cs_n_q  <= ~(NCS'(1) << bus.req_addr[ADDR_BITS +: CS_BITS]);
                    rdata_q <= '0;
                    fall_q  <= '0;
                    div_q   <= '0;
                    sclk_q  <= 1'b0;
                end
                SHIFT: if (div_q == DIV_LAST) begin
                    div_q  <= '0;
                    sclk_q <= ~sclk_q;
                    // Falling SCLK: sample MISO, advance MOSI, and finish after the last bit.
                    if (sclk_q) begin
                        fall_q <= fall_q + CW'(1);
                        sr_q   <= sr_q << 1;
                        mosi_q <= sr_q[W-2];
                        if (!write_q && fall_q >= CW'(HDR))
                            rdata_q[rx_idx] <= miso;
                        if (fall_q == n_q - CW'(1)) begin
                            state_q     <= GAP;
                            cs_n_q      <= '1;
                            mosi_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            gap_q       <= '0;
                        end
                    end
                end else begin
                    div_q <= div_q + DW'(1);
                end
                GAP: if (gap_q == GAP_LAST) state_q <= IDLE;
                     else gap_q <= gap_q + GW'(1);
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: directed checks of two controllers (CLK_DIV 1 and 3) against a byte-stream SPI slave model.
module tb_spi_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_write = 1'b0;
    logic [3:0]  t_nb = 4'd0;
    logic [24:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic        miso = 1'b0;
    logic        sclk_a, mosi_a, sclk_b, mosi_b;
    logic [1:0]  cs_n_a, cs_n_b;
    logic        sclk_m, mosi_m, rdy, rv;
    logic [1:0]  csm;
    logic [31:0] rdata_m;
    logic [63:0] stream = 64'hFFFFFFFF_11223344;
    logic [127:0] mosi_cap;
    int ecnt = 0, rises = 0, falls = 0, high_cnt, first_rise, gap_bad, rv_cnt;
    int n_tests = 0, n_fail = 0;

    spi_mem_ctrl_if #(.ADDR_BITS(24), .CS_BITS(1), .MAX_BYTES(4)) bus_a ();
    spi_mem_ctrl_if #(.ADDR_BITS(24), .CS_BITS(1), .MAX_BYTES(4)) bus_b ();

    spi_mem_ctrl dut_a (.clk(clk), .rst(rst), .bus(bus_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso), .cs_n(cs_n_a));
    spi_mem_ctrl #(.CLK_DIV(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso), .cs_n(cs_n_b));

    assign bus_a.req_valid     = t_valid & ~sel;
    assign bus_b.req_valid     = t_valid & sel;
    assign bus_a.req_write     = t_write;
    assign bus_b.req_write     = t_write;
    assign bus_a.req_num_bytes = t_nb;
    assign bus_b.req_num_bytes = t_nb;
    assign bus_a.req_addr      = t_addr;
    assign bus_b.req_addr      = t_addr;
    assign bus_a.req_wdata     = t_wdata;
    assign bus_b.req_wdata     = t_wdata;

    assign sclk_m  = sel ? sclk_b : sclk_a;
    assign mosi_m  = sel ? mosi_b : mosi_a;
    assign csm     = sel ? cs_n_b : cs_n_a;
    assign rdy     = sel ? bus_b.req_ready : bus_a.req_ready;
    assign rv      = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign rdata_m = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    // Slave model: capture MOSI on rising SCLK, present the next stream bit after each fall.
    always @(posedge sclk_m) begin
        mosi_cap = {mosi_cap[126:0], mosi_m};
        rises++;
    end
    always @(negedge sclk_m) begin
        falls++;
        miso = falls < 64 ? stream[63-falls] : 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit s, input bit w, input logic [3:0] nb, input logic [24:0] addr,
                        input logic [31:0] wd, input bit hold, input int abort_c,
                        output int rsp_c, output int rdy_c, output logic [31:0] rd,
                        output logic [1:0] cs1, output int rsp_e, output int acc_e);
        int t0, c, k;
        sel = s; t_write = w; t_nb = nb; t_addr = addr; t_wdata = wd; t_valid = 1'b1;
        rises = 0; falls = 0; mosi_cap = '0; miso = stream[63];
        high_cnt = 0; first_rise = 0; gap_bad = 0; rv_cnt = 0;
        rsp_c = 0; rdy_c = 0; rd = '0; cs1 = 2'b11; rsp_e = 0; acc_e = 0;
        k = 0;
        while (!rdy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!rdy) begin
            check("accept_timeout", 64'd0, 64'd1);
            t_valid = 1'b0;
            return;
        end
        t0 = ecnt + 1;
        acc_e = ecnt;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            c = ecnt - t0 + 1;
            if (c == 1) begin
                cs1 = csm;
                t_valid = hold;
            end
            if (sclk_m) begin
                high_cnt++;
                if (first_rise == 0) first_rise = c;
            end
            if (abort_c != 0 && c == abort_c) begin
                rst = 1'b1;
                @(negedge clk);
                check("abort_cs_n", 64'(csm), 64'h3);
                check("abort_sclk", 64'(sclk_m), 64'h0);
                check("abort_ready_in_rst", 64'(rdy), 64'h0);
                rst = 1'b0;
                return;
            end
            if (rv) begin
                rv_cnt++;
                if (rsp_c == 0) begin
                    rsp_c = c;
                    rd = rdata_m;
                    rsp_e = ecnt;
                end
            end
            if (rsp_c != 0 && (csm != 2'b11 || sclk_m || mosi_m)) gap_bad++;
            if (rsp_c != 0 && rdy) begin
                rdy_c = c;
                break;
            end
        end
        if (rdy_c == 0) check("xfer_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rc, yc, re, ae, re1, g1, rvc;
        logic [31:0] rd;
        logic [1:0]  c1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs_n", 64'(cs_n_a), 64'h3);
        check("rst_sclk", 64'(sclk_a), 64'h0);
        check("rst_mosi", 64'(mosi_a), 64'h0);
        check("rst_rsp_valid", 64'(bus_a.rsp_valid), 64'h0);
        check("rst_rdata", 64'(bus_a.rsp_rdata), 64'h0);
        check("rst_ready", 64'(bus_a.req_ready), 64'h1);

        xfer(0, 0, 4'd4, 25'h0_000100, 32'h0, 0, 0, rc, yc, rd, c1, re, ae);
        check("rd4_rsp_cycle", 64'(rc), 64'd129);
        check("rd4_ready_cycle", 64'(yc), 64'd131);
        check("rd4_rdata", 64'(rd), 64'h44332211);
        check("rd4_cs_n", 64'(c1), 64'h2);
        check("rd4_mosi_hdr", 64'(mosi_cap[63:32]), 64'h03000100);
        check("rd4_rises", 64'(rises), 64'd64);
        check("rd4_gap", 64'(gap_bad), 64'd0);
        check("rd4_rsp_pulses", 64'(rv_cnt), 64'd1);

        xfer(0, 1, 4'd2, 25'h1_ABCDEF, 32'h0000BEEF, 0, 0, rc, yc, rd, c1, re, ae);
        check("wr2_cs_n", 64'(c1), 64'h1);
        check("wr2_mosi", mosi_cap[63:0], 64'h0000_02AB_CDEF_EFBE);
        check("wr2_rises", 64'(rises), 64'd48);
        check("wr2_rdata", 64'(rd), 64'h0);
        check("wr2_rsp_cycle", 64'(rc), 64'd97);
        check("wr2_ready_cycle", 64'(yc), 64'd99);

        xfer(1, 0, 4'd1, 25'h0_000100, 32'h0, 0, 0, rc, yc, rd, c1, re, ae);
        check("div3_rsp_cycle", 64'(rc), 64'd241);
        check("div3_ready_cycle", 64'(yc), 64'd243);
        check("div3_rdata", 64'(rd), 64'h11);
        check("div3_rises", 64'(rises), 64'd40);
        check("div3_high_cycles", 64'(high_cnt), 64'd120);
        check("div3_first_rise", 64'(first_rise), 64'd4);
        check("div3_cs_n", 64'(c1), 64'h2);

        xfer(0, 0, 4'd0, 25'h0_000100, 32'h0, 0, 0, rc, yc, rd, c1, re, ae);
        check("nb0_rises", 64'(rises), 64'd64);
        check("nb0_rsp_cycle", 64'(rc), 64'd129);
        check("nb0_rdata", 64'(rd), 64'h44332211);
        xfer(0, 0, 4'd9, 25'h0_000100, 32'h0, 0, 0, rc, yc, rd, c1, re, ae);
        check("nb9_rises", 64'(rises), 64'd64);
        check("nb9_rsp_cycle", 64'(rc), 64'd129);
        check("nb9_rdata", 64'(rd), 64'h44332211);

        xfer(0, 0, 4'd1, 25'h0_000100, 32'h0, 1, 0, rc, yc, rd, c1, re, ae);
        re1 = re;
        g1 = gap_bad;
        check("b2b_first_rsp_cycle", 64'(rc), 64'd81);
        xfer(0, 0, 4'd1, 25'h0_000100, 32'h0, 0, 0, rc, yc, rd, c1, re, ae);
        check("b2b_accept_gap", 64'(ae - re1), 64'd2);
        check("b2b_gap_cs_n", 64'(g1), 64'd0);
        check("b2b_second_rdata", 64'(rd), 64'h11);

        xfer(0, 0, 4'd4, 25'h0_000100, 32'h0, 0, 50, rc, yc, rd, c1, re, ae);
        rvc = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus_a.rsp_valid) rvc++;
        end
        check("abort_no_rsp", 64'(rvc), 64'd0);
        check("abort_ready_after", 64'(bus_a.req_ready), 64'h1);
        xfer(0, 0, 4'd4, 25'h0_000100, 32'h0, 0, 0, rc, yc, rd, c1, re, ae);
        check("post_abort_rdata", 64'(rd), 64'h44332211);
        check("post_abort_rsp_cycle", 64'(rc), 64'd129);
        check("post_abort_mosi_hdr", 64'(mosi_cap[63:32]), 64'h03000100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Parametrised SPI master for external serial flash/RAM. It is the next-generation external memory port behind the CPU load/store and fetch path. Accepts one read or write request at a time over a valid/ready handshake and decodes the upper address bits onto one of `2**CS_BITS` active-low chip selects. It generates a divided, fully registered SPI mode-0 clock and returns little-endian read data with a single-cycle response pulse.

## Interface
Parameters:
- `ADDR_BITS`, 24: SPI address field width; multiple of 8, 8..32.
- `CS_BITS`, 1: chip-select decode bits, ≥1; `NUM_CS = 2**CS_BITS`.
- `MAX_BYTES`, 4: maximum data bytes per transaction, 1..8.
- `CLK_DIV`, 1: SCLK half-period in `clk` cycles, ≥1.
- `CS_GAP`, 2: `clk` cycles with all `cs_n` high between transactions, ≥1.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; request accepted on `req_valid & req_ready`.
- `req_write` in 1: 1 = write (opcode 0x02), 0 = read (opcode 0x03).
- `req_num_bytes` in 4: data byte count; 0 or >MAX_BYTES treated as MAX_BYTES.
- `req_addr` in CS_BITS+ADDR_BITS: `[ADDR_BITS +: CS_BITS]` = chip index, `[ADDR_BITS-1:0]` = SPI address.
- `req_wdata` in 8*MAX_BYTES: write data; byte 0 = `[7:0]`, sent first.
- `rsp_valid` out 1: one-cycle pulse at transaction end.
- `rsp_rdata` out 8*MAX_BYTES: read data; first received byte in `[7:0]`.
- `sclk` out 1, `mosi` out 1, `miso` in 1: SPI bus.
- `cs_n` out NUM_CS: active-low chip selects.

## Operation
- States: IDLE, SHIFT, GAP. `req_ready = (state==IDLE) & ~rst`.
- IDLE + handshake: latch the request. Build the shift register as {opcode, address MSB-first, data bytes byte0 first, each MSB-first}. Set bit count `N = 8 + ADDR_BITS + 8*nb`, where `nb` is the clamped byte count. Clear `rsp_rdata`. Go to SHIFT.
- SHIFT: assert `cs_n[idx]` low only, where `idx` is the latched chip index. `sclk` toggles every CLK_DIV cycles, starting low. `mosi` = shift-register MSB and changes only when `sclk` goes high→low.
- Sampling: `miso` is sampled at the `clk` edge where registered `sclk` leaves high. Only bits after the first `8+ADDR_BITS` are shifted into the receive register.
- Read data: received byte k is placed in `rsp_rdata[8k+7:8k]`. Bytes ≥nb read 0. For writes, `rsp_rdata` is 0.
- SHIFT ends after 2N half-periods, on the edge `sclk` returns low. Go to GAP: all `cs_n` high, `sclk` 0, `mosi` 0, `rsp_valid` = 1 for that first GAP cycle only.
- GAP lasts CS_GAP cycles, then IDLE. `rsp_rdata` holds until the next accept.
- `req_valid` while not ready is ignored. No queueing; requester must hold `req_valid` until accepted.
- Reset, including mid-transaction: state IDLE, `cs_n` all 1, `sclk` 0, `mosi` 0, `rsp_valid` 0, `rsp_rdata` 0, counters 0. No response is issued for an aborted transaction.

## Timing
- Accept edge = cycle 0. Cycle 1: `cs_n[idx]`=0, `sclk`=0, `mosi` = opcode bit 7.
- First `sclk` rise at cycle 1+CLK_DIV. Edge i (1-based) rises at cycle 1+(2i-1)·CLK_DIV.
- `rsp_valid` and `cs_n` release at cycle 1+2N·CLK_DIV.
- `req_ready` returns at cycle 1+2N·CLK_DIV+CS_GAP; earliest next accept is that cycle.
- Example, defaults, 4-byte read: N=64; `rsp_valid` at cycle 129; ready at cycle 131.
- All outputs are registered except `req_ready`. `sclk` is never combinationally derived from `clk`.

## Test plan
- Reset, then read: addr=0x0_000100, nb=4, model returns bytes 0x11,0x22,0x33,0x44. Expect: mosi stream 0x03,0x00,0x01,0x00; `cs_n`=2'b10; `rsp_rdata`=0x44332211; `rsp_valid` at cycle 129; ready at 131.
- Write: addr=0x1_ABCDEF, nb=2, wdata=0xBEEF. Expect: `cs_n`=2'b01; mosi 0x02,0xAB,0xCD,0xEF,0xEF,0xBE; N=48; `rsp_rdata`=0.
- Read, nb=1, CLK_DIV=3. Expect: `sclk` high/low 3 cycles each, 40 rising edges; `rsp_rdata[31:8]`=0; `rsp_valid` at cycle 241.
- nb=0 and nb=9. Expect: both run MAX_BYTES (N=64).
- Back-to-back: `req_valid` held high. Expect: second accept exactly CS_GAP cycles after `rsp_valid`; `cs_n` all high throughout the gap.
- `rst` asserted at cycle 50 of a read. Expect: next cycle `cs_n` all 1, `sclk` 0; no `rsp_valid`; `req_ready`=1 after `rst` drops; a subsequent read completes correctly.
